scoreboard_ctrl: RTL
====================

# scoreboard_ctrl

Front-end controller for the two-digit `Scoreboard` datapath. It turns three raw, bouncing push-buttons into the clean command strobes the scoreboard expects: single-cycle `inc_i` and `dec_i` pulses, and an `erase_i` level held for a fixed number of cycles. It synchronises, debounces and edge-detects each button, arbitrates simultaneous presses, and auto-repeats a held inc/dec button. It sits between the board I/O pins and the `Scoreboard` instance in the top level.

## Interface

Parameters:
- `DB_CYCLES`, 4: consecutive stable samples required before a debounced level changes. Use 4 in simulation; the board build overrides it.
- `ERASE_CYCLES`, 6: number of cycles `erase_o` is held high per erase command.
- `REPEAT_DELAY`, 16: cycles from the first inc/dec pulse to the first auto-repeat pulse.
- `REPEAT_PERIOD`, 8: cycles between subsequent auto-repeat pulses.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_inc_i`  in  1  raw increment button, asynchronous, active-high.
- `btn_dec_i`  in  1  raw decrement button, asynchronous, active-high.
- `btn_erase_i`  in  1  raw erase button, asynchronous, active-high.
- `inc_o`  out  1  one-cycle increment strobe, drives `Scoreboard.inc_i`.
- `dec_o`  out  1  one-cycle decrement strobe, drives `Scoreboard.dec_i`.
- `erase_o`  out  1  erase level, drives `Scoreboard.erase_i`.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation

Per-button conditioning:
- A 2-FF synchroniser feeds the debouncer.
- The debounced level flips only after `sync != level` for `DB_CYCLES` consecutive cycles. The counter clears on any matching sample.
- A press event is a rising edge of the debounced level. Releases generate no event.

FSM states: IDLE, HOLD_INC, HOLD_DEC, ERASE.
- **IDLE**, press priority is erase > inc > dec.
  - Erase press: go to ERASE.
  - Inc press: pulse `inc_o`, go to HOLD_INC.
  - Dec press: pulse `dec_o`, go to HOLD_DEC.
  - Lower-priority presses in the same cycle are dropped.
- **HOLD_x**:
  - Repeat counter runs while the held button's debounced level is high.
  - First repeat pulse comes `REPEAT_DELAY` cycles after the initial pulse, then one every `REPEAT_PERIOD` cycles.
  - Held button's debounced level low: go to IDLE; no pulse is issued in that cycle.
  - Erase press pre-empts the hold: go to ERASE.
  - Presses of the opposite direction are ignored.
- **ERASE**:
  - `erase_o` is high for exactly `ERASE_CYCLES` cycles, then the FSM returns to IDLE.
  - inc/dec presses during ERASE are dropped.
  - A still-held erase button does not retrigger, because commands are edge-based.

Invariants:
- At most one of `inc_o`, `dec_o`, `erase_o` is high in any cycle.
- All outputs are registered.
- Counters saturate and never wrap.

Reset:
- `rst` low forces all outputs to 0 immediately, the FSM to IDLE, and all synchronisers, debounced levels and counters to 0.
- A button still held when reset is released is seen as a new press once it has debounced.

## Timing

- Press latency: raw high first sampled at edge k, so `inc_o`/`dec_o` rises after edge k+2+`DB_CYCLES` (edge k+6 with defaults) and falls one edge later.
- Erase latency: same latency as a press; `erase_o` is high for `ERASE_CYCLES` clock cycles.
- Glitches shorter than `DB_CYCLES` cycles at the synchroniser output produce no event.
- Auto-repeat: initial pulse at edge P, repeats at P+`REPEAT_DELAY`+n·`REPEAT_PERIOD` for n ≥ 0 while the button is held.
- `busy_o` is registered with the state and is high from the edge that enters HOLD_x or ERASE.

## Structure

- Package `scoreboard_ctrl_pkg` holds:
  - the FSM state encoding;
  - the default values of the four parameters;
  - the button index constants ERASE=0, INC=1, DEC=2, which also define the priority order.
- Sub-module `button_conditioner` (sync + debounce + edge detect, parameter `DB_CYCLES`) is instantiated three times. It outputs the debounced level and a one-cycle press event.
- The top level contains only the arbitration FSM and the repeat/erase counters.

## Test plan

1. **Reset:** `rst` low with all buttons high. Required: all outputs 0 while reset is asserted; after release, exactly one `erase_o` burst of 6 cycles after debounce.
2. **Single inc:** raw inc high for 10 cycles. Required: exactly one `inc_o` pulse, rising 6 edges after the first sampling edge; `busy_o` falls after debounced release.
3. **Bounce:** raw dec toggling every 2 cycles for 12 cycles, then stable high for 6 cycles. Required: exactly one `dec_o` pulse, only after the stable period.
4. **Auto-repeat:** inc held for 50 cycles after its first pulse at edge P. Required: pulses at P, P+16, P+24, P+32, P+40, P+48; none after release.
5. **Arbitration:** inc and erase raised in the same cycle. Required: erase burst only, no `inc_o`. In a second case, erase pressed during HOLD_DEC. Required: repeats stop and an erase burst follows.
6. **Reset mid-erase:** `rst` pulsed low on the 3rd cycle of `erase_o`. Required: `erase_o` drops immediately and `busy_o` is 0.

Source files
------------

// File: rtl/scoreboard_ctrl_pkg.sv
// Shared definitions for the scoreboard front-end controller:
// FSM state encoding, parameter defaults and button index constants.
// The button index order (ERASE, INC, DEC) is also the press priority order.
package scoreboard_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD_INC = 2'd1,
        S_HOLD_DEC = 2'd2,
        S_ERASE    = 2'd3
    } state_e;

    localparam int DEF_DB_CYCLES     = 4;
    localparam int DEF_ERASE_CYCLES  = 6;
    localparam int DEF_REPEAT_DELAY  = 16;
    localparam int DEF_REPEAT_PERIOD = 8;

    localparam int ERASE   = 0;
    localparam int INC     = 1;
    localparam int DEC     = 2;
    localparam int NUM_BTN = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Conditions one raw push-button: 2-FF synchroniser, debouncer, rising-edge detect.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   btn_i    raw asynchronous button, active-high
//   level_o  debounced button level
//   press_o  one-cycle pulse on a rising edge of the debounced level
module button_conditioner
    import scoreboard_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips on the DB_CYCLES-th consecutive mismatching sample;
    // any matching sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/scoreboard_ctrl.sv
// Scoreboard front-end: turns three bouncing buttons into clean inc/dec strobes
// (with auto-repeat while held) and a fixed-length erase level.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   btn_inc_i    raw increment button
//   btn_dec_i    raw decrement button
//   btn_erase_i  raw erase button
//   inc_o        one-cycle increment strobe
//   dec_o        one-cycle decrement strobe
//   erase_o      erase level, ERASE_CYCLES long
//   busy_o       high whenever the FSM is not idle
//
// state      | meaning
// S_IDLE     | waiting for a press (priority erase > inc > dec)
// S_HOLD_INC | inc held, auto-repeating inc_o
// S_HOLD_DEC | dec held, auto-repeating dec_o
// S_ERASE    | driving erase_o for ERASE_CYCLES cycles
module scoreboard_ctrl
    import scoreboard_ctrl_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_inc_i,
    input  logic btn_dec_i,
    input  logic btn_erase_i,
    output logic inc_o,
    output logic dec_o,
    output logic erase_o,
    output logic busy_o
);

    localparam int CW = $clog2(max2(max2(REPEAT_DELAY, REPEAT_PERIOD), ERASE_CYCLES) + 1);

    logic [NUM_BTN-1:0] raw, level, press;

    assign raw[ERASE] = btn_erase_i;
    assign raw[INC]   = btn_inc_i;
    assign raw[DEC]   = btn_dec_i;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        button_conditioner #(
            .DB_CYCLES (DB_CYCLES)
        ) u_cond (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (raw[b]),
            .level_o (level[b]),
            .press_o (press[b])
        );
    end

    // Erase is purely edge-triggered; its debounced level is not needed.
    logic unused_erase_level;
    assign unused_erase_level = level[ERASE];

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inc_q, inc_d, dec_q, dec_d, erase_q, erase_d, busy_q;
    logic          held;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        erase_d = 1'b0;
        held    = (state_q == S_HOLD_INC) ? level[INC] : level[DEC];
        case (state_q)
            S_IDLE: begin
                if (press[ERASE]) begin
                    state_d = S_ERASE;
                    cnt_d   = CW'(ERASE_CYCLES - 1);
                    erase_d = 1'b1;
                end else if (press[INC]) begin
                    state_d = S_HOLD_INC;
                    cnt_d   = CW'(REPEAT_DELAY - 1);
                    inc_d   = 1'b1;
                end else if (press[DEC]) begin
                    state_d = S_HOLD_DEC;
                    cnt_d   = CW'(REPEAT_DELAY - 1);
                    dec_d   = 1'b1;
                end
            end
            S_HOLD_INC, S_HOLD_DEC: begin
                if (press[ERASE]) begin
                    state_d = S_ERASE;
                    cnt_d   = CW'(ERASE_CYCLES - 1);
                    erase_d = 1'b1;
                end else if (!held) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    // Terminal count: emit a repeat and reload for the next period.
                    cnt_d = CW'(REPEAT_PERIOD - 1);
                    inc_d = (state_q == S_HOLD_INC);
                    dec_d = (state_q == S_HOLD_DEC);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ERASE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    erase_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            erase_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            erase_q <= erase_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign inc_o   = inc_q;
    assign dec_o   = dec_q;
    assign erase_o = erase_q;
    assign busy_o  = busy_q;

endmodule
